// File: rtl/sha256_msg_sched_ctrl.sv
// SHA-256 message-schedule sequencer: loads 16 block words and streams W[0..63],
// computing W[16..63] through an external combinational sigma unit.
module sha256_msg_sched_ctrl #(
    parameter logic [1:0] OP_SIG0 = 2'b00,
    parameter logic [1:0] OP_SIG1 = 2'b01
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        start,
    input  logic        flush,
    output logic        busy,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_idx,
    output logic        out_last,
    output logic        fu_valid,
    output logic [1:0]  fu_op,
    output logic [31:0] fu_rs1,
    input  logic [31:0] fu_result
);

    localparam int unsigned W_DATA = 32;
    localparam int unsigned W_IDX  = 6;
    localparam int unsigned W_PTR  = 4;
    localparam int unsigned DEPTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT,
        ST_S1,
        ST_S0,
        ST_OUT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [W_DATA-1:0]   r_buf [DEPTH];
    logic [W_IDX-1:0]    r_t;
    logic [W_DATA-1:0]   r_acc;
    logic [W_DATA-1:0]   r_wreg;

    logic                w_in_hs;
    logic                w_out_hs;
    logic [W_PTR-1:0]    w_i0;
    logic [W_PTR-1:0]    w_im2;
    logic [W_PTR-1:0]    w_im7;
    logic [W_PTR-1:0]    w_im15;
    logic [W_DATA-1:0]   w_sum;

    // Circular-buffer taps; all index arithmetic wraps mod 16.
    assign w_i0     = r_t[W_PTR-1:0];
    assign w_im2    = w_i0 - 4'd2;
    assign w_im7    = w_i0 - 4'd7;
    assign w_im15   = w_i0 - 4'd15;
    assign w_sum    = r_acc + fu_result;
    assign w_in_hs  = in_valid && (r_state == ST_LOAD);
    assign w_out_hs = out_ready && ((r_state == ST_EMIT) || (r_state == ST_OUT));

    // State register
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)                          w_state_nxt = ST_LOAD;
            ST_LOAD: if (w_in_hs && (w_i0 == 4'd15))     w_state_nxt = ST_EMIT;
            ST_EMIT: if (w_out_hs && (w_i0 == 4'd15))    w_state_nxt = ST_S1;
            ST_S1:                                       w_state_nxt = ST_S0;
            ST_S0:                                       w_state_nxt = ST_OUT;
            ST_OUT: begin
                if (w_out_hs) begin
                    w_state_nxt = (r_t == 6'd63) ? ST_IDLE : ST_S1;
                end
            end
            default:                                     w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Counter, accumulator and result register
    always_ff @(posedge g_clk) begin
        if (!g_resetn || flush) begin
            r_t    <= '0;
            r_acc  <= '0;
            r_wreg <= '0;
        end else begin
            case (r_state)
                ST_IDLE: r_t <= '0;
                ST_LOAD: begin
                    if (w_in_hs) begin
                        r_t <= (w_i0 == 4'd15) ? '0 : r_t + 6'd1;
                    end
                end
                ST_EMIT: begin
                    if (w_out_hs) begin
                        r_t <= r_t + 6'd1;
                    end
                end
                ST_S1: r_acc  <= fu_result + r_buf[w_im7] + r_buf[w_i0];
                ST_S0: r_wreg <= w_sum;
                ST_OUT: begin
                    if (w_out_hs) begin
                        r_t <= (r_t == 6'd63) ? '0 : r_t + 6'd1;
                    end
                end
                default: r_t <= '0;
            endcase
        end
    end

    // Word buffer is deliberately not reset; LOAD overwrites it before use
    always_ff @(posedge g_clk) begin
        if (g_resetn && !flush) begin
            if (w_in_hs) begin
                r_buf[w_i0] <= in_data;
            end else if (r_state == ST_S0) begin
                r_buf[w_i0] <= w_sum;
            end
        end
    end

    // Output decode from the registered state
    always_comb begin
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        fu_valid  = 1'b0;
        fu_op     = '0;
        fu_rs1    = '0;
        case (r_state)
            ST_IDLE: ;
            ST_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
            end
            ST_EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = r_buf[w_i0];
                out_idx   = r_t;
            end
            ST_S1: begin
                busy     = 1'b1;
                fu_valid = 1'b1;
                fu_op    = OP_SIG1;
                fu_rs1   = r_buf[w_im2];
            end
            ST_S0: begin
                busy     = 1'b1;
                fu_valid = 1'b1;
                fu_op    = OP_SIG0;
                fu_rs1   = r_buf[w_im15];
            end
            ST_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = r_wreg;
                out_idx   = r_t;
                out_last  = (r_t == 6'd63);
            end
            default: ;
        endcase
    end

endmodule
